vga_fb_arbiter: RTL and testbench

//  Time-slot arbiter for a single-port synchronous frame-buffer RAM (QVGA, 2x upscaled to 640x480).

---
 rtl/vga_fb_pkg.sv | 29 ++
 rtl/fb_wr_fifo.sv | 45 ++++
 rtl/vga_fb_arbiter.sv | 124 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// rtl/vga_fb_pkg.sv - frame-buffer geometry, owner encoding and write-request types
package vga_fb_pkg;

  localparam int FB_W   = 320;
  localparam int FB_H   = 240;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;

  typedef logic [DATA_W-1:0] rgb_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {OWN_IDLE, OWN_RD, OWN_WR} owner_t;

  typedef struct packed {
    addr_t addr;
    rgb_t  data;
  } wr_req_t;

  // Display pixel (x, y) maps to buffer pixel (x/2, y/2); 320 = 256 + 64
  function automatic addr_t fb_addr(input logic [9:0] x, input logic [9:0] y);
    addr_t xh;
    addr_t yh;
    xh = addr_t'(x >> 1);
    yh = addr_t'(y >> 1);
    if (FB_W == 320) return (yh << 8) + (yh << 6) + xh;
    else return (yh * addr_t'(FB_W)) + xh;
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - synchronous write-request FIFO, power-of-2 depth
module fb_wr_fifo
  import vga_fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wr_req_t push_data,
  input  logic    pop,
  output wr_req_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);

  wr_req_t     mem [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit separates full from empty when the indices match
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - display/writer time-slot arbiter for a single-port frame buffer
// Optional statistics counters: VGA_FB_ARB_STATS_EN
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_tick,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic              DE,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rgb_out,
  output logic              de_out,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       stall_cnt
);

  logic [1:0] slot_q;
  logic [1:0] slot;
  logic       rst_done;
  logic       active;
  owner_t     owner_q;
  owner_t     owner_d;
  wr_req_t    head;
  logic       fifo_full;
  logic       fifo_empty;

  // Keeps every output at 0 while reset is applied and for the cycle after it
  assign active   = reset && rst_done;
  assign slot     = pix_tick ? 2'd0 : slot_q;
  assign wr_ready = active && !fifo_full;

  fb_wr_fifo #(.DEPTH(WFIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_valid && wr_ready),
    .push_data ('{addr: wr_addr, data: wr_data}),
    .pop       (owner_d == OWN_WR),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_q   <= 2'd3;
      rst_done <= 1'b0;
      owner_q  <= OWN_IDLE;
    end else begin
      slot_q   <= (slot == 2'd3) ? 2'd3 : slot + 2'd1;
      rst_done <= 1'b1;
      owner_q  <= owner_d;
    end
  end

  always_comb begin
    owner_d = OWN_IDLE;
    if (active) begin
      if (slot == 2'd0 && DE) owner_d = OWN_RD;
      else if (!fifo_empty)   owner_d = OWN_WR;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner_d)
      OWN_RD: begin
        mem_en   = 1'b1;
        mem_addr = fb_addr(x_pixel, y_pixel);
      end
      OWN_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head.addr;
        mem_wdata = head.data;
      end
      default: ;
    endcase
  end

  // A blanking tick overrides a capture landing on the same edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb_out <= '0;
      de_out  <= 1'b0;
    end else if (pix_tick && !DE) begin
      rgb_out <= '0;
      de_out  <= 1'b0;
    end else if (owner_q == OWN_RD) begin
      rgb_out <= mem_rdata;
      de_out  <= 1'b1;
    end
  end

`ifdef VGA_FB_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pix_tick && x_pixel == 10'd0 && y_pixel == 10'd0) frame_cnt <= frame_cnt + 16'd1;
      if (wr_valid && !wr_ready && stall_cnt != 16'hFFFF)     stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign frame_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - scoreboard bench for vga_fb_arbiter with a behavioural single-port RAM
module tb_vga_fb_arbiter;

  typedef struct {
    logic [16:0] addr;
    logic [11:0] data;
  } wexp_t;

  typedef struct {
    int          due;
    logic [11:0] val;
    logic        de;
  } pix_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_tick;
  logic [9:0]  x_pixel;
  logic [9:0]  y_pixel;
  logic        DE;
  logic        wr_valid;
  logic        wr_ready;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata = 12'h0;
  logic [11:0] rgb_out;
  logic        de_out;
  logic [15:0] frame_cnt;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  int we_count = 0;
  logic wr_auto = 1'b0;

  logic [11:0] ram [0:131071];
  wexp_t sb_wr[$];
  pix_t  pix_q[$];
  wexp_t wr_todo[$];

  logic [16:0] last_addr;
  logic        last_en;
  logic        last_we;
  logic [11:0] last_rgb;
  logic        last_de;

  vga_fb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .pix_tick  (pix_tick),
    .x_pixel   (x_pixel),
    .y_pixel   (y_pixel),
    .DE        (DE),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rgb_out   (rgb_out),
    .de_out    (de_out),
    .frame_cnt (frame_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  wexp_t e;
  pix_t  p;
  int    ea;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      sb_wr.delete();
      pix_q.delete();
    end else begin
      if (wr_valid && wr_ready) sb_wr.push_back('{addr: wr_addr, data: wr_data});
      if (mem_en && mem_we) begin
        we_count++;
        check("wr_slot0_free", 32'(pix_tick && DE), 32'd0);
        check("wr_pending", 32'(sb_wr.size() > 0), 32'd1);
        if (sb_wr.size() > 0) begin
          e = sb_wr.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", 32'(mem_wdata), 32'(e.data));
        end
      end
      if (pix_tick && DE) begin
        ea = (int'(y_pixel) / 2) * 320 + int'(x_pixel) / 2;
        check("rd_en", 32'(mem_en), 32'd1);
        check("rd_we", 32'(mem_we), 32'd0);
        check("rd_addr", 32'(mem_addr), 32'(ea));
        pix_q.push_back('{due: cyc + 2, val: ram[ea], de: 1'b1});
      end else begin
        check("no_stray_rd", 32'(mem_en && !mem_we), 32'd0);
      end
      if (pix_tick && !DE) begin
        if (pix_q.size() > 0 && pix_q[$].due == cyc + 1) void'(pix_q.pop_back());
        pix_q.push_back('{due: cyc + 1, val: 12'h0, de: 1'b0});
      end
      if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
        p = pix_q.pop_front();
        check("pix_rgb", 32'(rgb_out), 32'(p.val));
        check("pix_de", 32'(de_out), 32'(p.de));
      end
    end
  end

  // Offers queued writes in order, advancing only on an accepted transfer
  logic acc;
  initial begin
    forever begin
      @(negedge clk);
      acc = wr_auto && reset && wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (acc && wr_todo.size() > 0) begin
        void'(wr_todo.pop_front());
        n_acc++;
      end
      if (wr_auto) begin
        if (wr_todo.size() > 0) begin
          wr_valid = 1'b1;
          wr_addr  = wr_todo[0].addr;
          wr_data  = wr_todo[0].data;
        end else begin
          wr_valid = 1'b0;
        end
      end
    end
  end

  task automatic pixel(input int x, input int y, input logic de);
    x_pixel  = 10'(x);
    y_pixel  = 10'(y);
    DE       = de;
    pix_tick = 1'b1;
    @(negedge clk);
    last_addr = mem_addr;
    last_en   = mem_en;
    last_we   = mem_we;
    step();
    pix_tick = 1'b0;
    step();
    @(negedge clk);
    last_rgb = rgb_out;
    last_de  = de_out;
    step();
    step();
  endtask

  task automatic pin_reads(input int x, input int y);
    x_pixel  = 10'(x);
    y_pixel  = 10'(y);
    DE       = 1'b1;
    pix_tick = 1'b1;
  endtask

  int nwe;

  initial begin
    reset = 1'b0; pix_tick = 1'b0; DE = 1'b0; x_pixel = '0; y_pixel = '0;
    wr_valid = 1'b1; wr_addr = 17'h123; wr_data = 12'hABC;
    for (int i = 0; i < 131072; i++) ram[i] = 12'h0;
    ram[0] = 12'hF00; ram[641] = 12'h0A5; ram[76799] = 12'h5A5;

    // reset held with a pending writer
    repeat (3) begin
      @(negedge clk);
      check("t1_mem_en", 32'(mem_en), 32'd0);
      check("t1_rgb", 32'(rgb_out), 32'd0);
      check("t1_de", 32'(de_out), 32'd0);
      check("t1_wr_ready", 32'(wr_ready), 32'd0);
    end
    step();
    reset = 1'b1; wr_valid = 1'b0;
    step();
    @(negedge clk);
    check("t1_ready_after", 32'(wr_ready), 32'd1);
    step();
    wr_auto = 1'b1;

    // first pixel and address mapping
    pixel(0, 0, 1'b1);
    check("t2_addr", 32'(last_addr), 32'd0);
    check("t2_we", 32'(last_we), 32'd0);
    check("t2_rgb", 32'(last_rgb), 32'hF00);
    check("t2_de", 32'(last_de), 32'd1);
    pixel(6, 0, 1'b1);
    pixel(3, 5, 1'b1);
    check("t3_addr_641", 32'(last_addr), 32'd641);
    check("t3_rgb_641", 32'(last_rgb), 32'h0A5);
    pixel(639, 479, 1'b1);
    check("t3_addr_76799", 32'(last_addr), 32'd76799);
    check("t3_rgb_76799", 32'(last_rgb), 32'h5A5);

    // six writes against a display that owns every cycle
    n_acc = 0;
    for (int i = 0; i < 6; i++)
      wr_todo.push_back('{addr: (i == 5) ? 17'h1FFFF : 17'(1000 * i + 7), data: 12'($urandom_range(0, 4095))});
    pin_reads(10, 10);
    repeat (8) step();
    check("t4_accepted", 32'(n_acc), 32'd4);
    @(negedge clk);
    check("t4_ready_low", 32'(wr_ready), 32'd0);
    step();
    for (int i = 0; i < 6; i++) pixel(2 * i, 20, 1'b1);
    check("t4_todo_empty", 32'(wr_todo.size()), 32'd0);
    check("t4_drained", 32'(sb_wr.size()), 32'd0);

    // blanking: four queued writes drain back-to-back from slot 0
    n_acc = 0;
    for (int i = 0; i < 4; i++) wr_todo.push_back('{addr: 17'(20000 + i), data: 12'(16'h100 + i)});
    pin_reads(8, 8);
    for (int k = 0; k < 20 && n_acc < 4; k++) step();
    check("t5_queued", 32'(n_acc), 32'd4);
    x_pixel = 10'd0; y_pixel = 10'd100; DE = 1'b0; pix_tick = 1'b1;
    @(negedge clk);
    check("t5_we_slot0", 32'(mem_we), 32'd1);
    nwe = int'(mem_we);
    step();
    pix_tick = 1'b0;
    repeat (3) begin
      @(negedge clk);
      nwe += int'(mem_we);
      step();
    end
    check("t5_we_run", 32'(nwe), 32'd4);
    @(negedge clk);
    check("t5_rgb_blank", 32'(rgb_out), 32'd0);
    check("t5_de_blank", 32'(de_out), 32'd0);
    step();

    // reset discards queued writes
    n_acc = 0;
    for (int i = 0; i < 3; i++) wr_todo.push_back('{addr: 17'(30000 + i), data: 12'hEEE});
    pin_reads(4, 4);
    for (int k = 0; k < 20 && n_acc < 3; k++) step();
    check("t6_queued", 32'(n_acc), 32'd3);
    reset = 1'b0; pix_tick = 1'b0; DE = 1'b0;
    step();
    reset = 1'b1;
    we_count = 0;
    step();
    for (int i = 0; i < 3; i++) pixel(100 + 2 * i, 0, 1'b0);
    check("t6_no_we", 32'(we_count), 32'd0);
    check("t6_ram_untouched", 32'(ram[30000]), 32'd0);
    pixel(0, 0, 1'b1);
    check("t6_rgb", 32'(last_rgb), 32'hF00);
`ifdef VGA_FB_ARB_STATS_EN
    check("t6_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t6_stall_cnt", 32'(stall_cnt), 32'd0);
`else
    check("t6_frame_tied", 32'(frame_cnt), 32'd0);
    check("t6_stall_tied", 32'(stall_cnt), 32'd0);
`endif

    // writer still works after reset
    wr_todo.push_back('{addr: 17'd555, data: 12'h321});
    wr_todo.push_back('{addr: 17'd556, data: 12'h654});
    for (int i = 0; i < 3; i++) pixel(2 * i, 30, 1'b1);
    check("t6_post_drained", 32'(sb_wr.size() + wr_todo.size()), 32'd0);
    check("t6_ram_555", 32'(ram[555]), 32'h321);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
